// File: rtl/ewrapper_txq_pkg.sv
// Shared packet layout and grant encoding for the emesh transmit queue.
// The packet is {datamode, ctrlmode, dstaddr, srcaddr, data}, data in the LSBs.
package ewrapper_txq_pkg;

  localparam int MODE_W = 2;
  localparam int CTRL_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int PKT_W = MODE_W + CTRL_W + 2 * ADDR_W + DATA_W;

  localparam int DATA_LSB = 0;
  localparam int SRC_LSB  = DATA_LSB + DATA_W;
  localparam int DST_LSB  = SRC_LSB + ADDR_W;
  localparam int CTRL_LSB = DST_LSB + ADDR_W;
  localparam int MODE_LSB = CTRL_LSB + CTRL_W;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/ewrapper_txq_fifo.sv
// Single-clock FIFO with a combinational head. A push while full is dropped
// and reported as a one-cycle ovf pulse; full is taken from the registered count.
module ewrapper_txq_fifo
  import ewrapper_txq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = PKT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign ovf     = push & full;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ewrapper_emesh_tx_queue.sv
// Two-channel (write/read) transmit queue feeding the emesh link through one output register.
// Define EWRAPPER_TXQ_WR_PRIORITY_EN for strict write priority instead of round-robin.
module ewrapper_emesh_tx_queue
  import ewrapper_txq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        emesh_clk_inb,
  input  logic        reset,
  input  logic        wr_access_in,
  input  logic [1:0]  wr_datamode_in,
  input  logic [3:0]  wr_ctrlmode_in,
  input  logic [31:0] wr_dstaddr_in,
  input  logic [31:0] wr_srcaddr_in,
  input  logic [31:0] wr_data_in,
  output logic        wr_wait_out,
  input  logic        rd_access_in,
  input  logic [1:0]  rd_datamode_in,
  input  logic [3:0]  rd_ctrlmode_in,
  input  logic [31:0] rd_dstaddr_in,
  input  logic [31:0] rd_srcaddr_in,
  input  logic [31:0] rd_data_in,
  output logic        rd_wait_out,
  output logic        emesh_access_outb,
  output logic        emesh_write_outb,
  output logic [1:0]  emesh_datamode_outb,
  output logic [3:0]  emesh_ctrlmode_outb,
  output logic [31:0] emesh_dstaddr_outb,
  output logic [31:0] emesh_srcaddr_outb,
  output logic [31:0] emesh_data_outb,
  input  logic        emesh_wr_wait_inb,
  input  logic        emesh_rd_wait_inb,
  output logic        overflow
);

  logic [PKT_W-1:0] wr_pkt_in, rd_pkt_in;
  logic [PKT_W-1:0] wr_head, rd_head;
  logic             wr_empty, rd_empty;
  logic             wr_full, rd_full;
  logic             wr_ovf, rd_ovf;
  logic             wr_pop, rd_pop;

  logic             oreg_valid_q, oreg_valid_d;
  logic             oreg_write_q, oreg_write_d;
  logic [PKT_W-1:0] oreg_pkt_q, oreg_pkt_d;
  logic             overflow_q, overflow_d;

  logic             link_wait;
  logic             accept;
  logic             load_en;
  logic             load_fire;
  logic             wr_elig, rd_elig;
  grant_e           tie_grant;
  grant_e           grant;

  assign wr_pkt_in = {wr_datamode_in, wr_ctrlmode_in, wr_dstaddr_in, wr_srcaddr_in, wr_data_in};
  assign rd_pkt_in = {rd_datamode_in, rd_ctrlmode_in, rd_dstaddr_in, rd_srcaddr_in, rd_data_in};

  ewrapper_txq_fifo #(.DEPTH(DEPTH), .AW(AW), .W(PKT_W)) u_wr_fifo (
    .clk   (emesh_clk_inb),
    .rst   (reset),
    .push  (wr_access_in),
    .pop   (wr_pop),
    .din   (wr_pkt_in),
    .dout  (wr_head),
    .empty (wr_empty),
    .full  (wr_full),
    .ovf   (wr_ovf)
  );

  ewrapper_txq_fifo #(.DEPTH(DEPTH), .AW(AW), .W(PKT_W)) u_rd_fifo (
    .clk   (emesh_clk_inb),
    .rst   (reset),
    .push  (rd_access_in),
    .pop   (rd_pop),
    .din   (rd_pkt_in),
    .dout  (rd_head),
    .empty (rd_empty),
    .full  (rd_full),
    .ovf   (rd_ovf)
  );

  // Link handshake: the OREG transaction is taken when access is high and the
  // wait input of its own type is low in that cycle; outputs hold until then.
  assign link_wait = oreg_write_q ? emesh_wr_wait_inb : emesh_rd_wait_inb;
  assign accept    = oreg_valid_q & ~link_wait;
  assign load_en   = ~oreg_valid_q | accept;
  assign wr_elig   = ~wr_empty & ~emesh_wr_wait_inb;
  assign rd_elig   = ~rd_empty & ~emesh_rd_wait_inb;
  assign load_fire = load_en & (wr_elig | rd_elig);

`ifdef EWRAPPER_TXQ_WR_PRIORITY_EN
  assign tie_grant = GNT_WR;
`else
  grant_e last_grant_q, last_grant_d;

  assign tie_grant = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;

  always_comb begin
    last_grant_d = last_grant_q;
    if (load_fire) last_grant_d = grant;
  end

  // Starts at read so the write channel takes the first tie after reset.
  always_ff @(posedge emesh_clk_inb or posedge reset) begin
    if (reset) last_grant_q <= GNT_RD;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    if (wr_elig && rd_elig) grant = tie_grant;
    else if (rd_elig)       grant = GNT_RD;
    else                    grant = GNT_WR;
  end

  always_comb begin
    oreg_valid_d = oreg_valid_q;
    oreg_write_d = oreg_write_q;
    oreg_pkt_d   = oreg_pkt_q;
    wr_pop       = 1'b0;
    rd_pop       = 1'b0;
    if (load_en) begin
      if (load_fire) begin
        oreg_valid_d = 1'b1;
        oreg_write_d = (grant == GNT_WR);
        oreg_pkt_d   = (grant == GNT_WR) ? wr_head : rd_head;
        wr_pop       = (grant == GNT_WR);
        rd_pop       = (grant == GNT_RD);
      end else begin
        // Nothing eligible: drop valid but keep the field values on the bus.
        oreg_valid_d = 1'b0;
      end
    end
  end

  assign overflow_d = overflow_q | wr_ovf | rd_ovf;

  always_ff @(posedge emesh_clk_inb or posedge reset) begin
    if (reset) begin
      oreg_valid_q <= 1'b0;
      oreg_write_q <= 1'b0;
      oreg_pkt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      oreg_valid_q <= oreg_valid_d;
      oreg_write_q <= oreg_write_d;
      oreg_pkt_q   <= oreg_pkt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign emesh_access_outb   = oreg_valid_q;
  assign emesh_write_outb    = oreg_write_q;
  assign emesh_datamode_outb = oreg_pkt_q[MODE_LSB +: MODE_W];
  assign emesh_ctrlmode_outb = oreg_pkt_q[CTRL_LSB +: CTRL_W];
  assign emesh_dstaddr_outb  = oreg_pkt_q[DST_LSB +: ADDR_W];
  assign emesh_srcaddr_outb  = oreg_pkt_q[SRC_LSB +: ADDR_W];
  assign emesh_data_outb     = oreg_pkt_q[DATA_LSB +: DATA_W];
  assign wr_wait_out         = wr_full;
  assign rd_wait_out         = rd_full;
  assign overflow            = overflow_q;

endmodule
